wino_tile_scheduler: RTL and testbench

Sequencer for the Winograd PE datapath. It walks a convolution layer's output-channel, tile-row, tile-column and input-channel loops, and issues one tile request per step to the input-transform and weight-transform feeders. It bounds in-flight tiles with a credit counter driven by PE result returns, then signals layer completion. It sits between the layer-control registers and the Itrans/Wtrans front end of the PE array.

---
 rtl/wino_pkg.sv | 24 ++
 rtl/wino_tile_scheduler_if.sv | 28 ++
 rtl/wino_loop_ctr.sv | 34 +++
 rtl/wino_tile_scheduler.sv | 157 +++++++++++++++
 tb/tb_wino_tile_scheduler.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wino_pkg.sv
// Shared types and constants for the Winograd tile scheduler: FSM states,
// tile steps for the two kernel size types, and index widths.
package wino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int TILE_STEP_1X1 = 6;
    localparam int TILE_STEP_3X3 = 4;

    localparam int IDX_W  = 9;
    localparam int OD_W   = 8;
    localparam int ID_W   = 4;
    localparam int PERF_W = 24;

    function automatic logic [IDX_W-1:0] tile_step(input logic size_type);
        return size_type ? IDX_W'(TILE_STEP_3X3) : IDX_W'(TILE_STEP_1X1);
    endfunction

endpackage

// File: rtl/wino_tile_scheduler_if.sv
// Tile request bundle between the scheduler (master) and the
// Itrans/Wtrans feeders (slave).
interface wino_tile_scheduler_if;
    import wino_pkg::*;

    logic             req_valid_o;
    logic             data_ready_i;
    logic             weight_ready_i;
    logic [IDX_W-1:0] data_x_index_o;
    logic [IDX_W-1:0] data_y_index_o;
    logic [ID_W-1:0]  tile_id_o;
    logic [OD_W-1:0]  weight_od_o;
    logic             weight_size_type_o;
    logic             last_id_o;

    modport master (
        output req_valid_o, data_x_index_o, data_y_index_o, tile_id_o,
               weight_od_o, weight_size_type_o, last_id_o,
        input  data_ready_i, weight_ready_i
    );

    modport slave (
        input  req_valid_o, data_x_index_o, data_y_index_o, tile_id_o,
               weight_od_o, weight_size_type_o, last_id_o,
        output data_ready_i, weight_ready_i
    );

endinterface

// File: rtl/wino_loop_ctr.sv
// One loop level of the tile walk: advances by step on inc and wraps to 0
// once value+step reaches bound; wrap_o feeds the next outer level.
module wino_loop_ctr #(
    parameter int W  = 9,
    parameter int BW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    input  logic [W-1:0]  step,
    input  logic [BW-1:0] bound,
    output logic [W-1:0]  value,
    output logic          wrap_o
);

    localparam int CW = ((W > BW) ? W : BW) + 1;

    logic [CW-1:0] sum;

    // The extra bit keeps value+step from overflowing before the compare.
    assign sum    = CW'(value) + CW'(step);
    assign wrap_o = (sum >= CW'(bound));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset || clear)
            value <= '0;
        else if (inc)
            value <= wrap_o ? '0 : sum[W-1:0];
    end

endmodule

// File: rtl/wino_tile_scheduler.sv
// Winograd tile scheduler: walks id -> y -> x -> od, issues credit-limited
// tile requests and pulses done. Optional perf counters: WINO_SCHED_PERF_EN.
module wino_tile_scheduler
    import wino_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [8:0]             cfg_h_i,
    input  logic [8:0]             cfg_w_i,
    input  logic [4:0]             cfg_id_i,
    input  logic [7:0]             cfg_od_i,
    input  logic                   cfg_size_type_i,
    wino_tile_scheduler_if.master  req,
    input  logic                   result_valid_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [PERF_W-1:0]      perf_cycles_o,
    output logic [PERF_W-1:0]      perf_stalls_o
);

    state_t           state, state_next;
    logic [8:0]       cfg_h, cfg_w;
    logic [4:0]       cfg_id;
    logic [7:0]       cfg_od;
    logic             size_type;
    logic [CNT_W-1:0] outstanding, outstanding_next;
    logic             armed;
    logic             req_valid, fire, final_fire, result_dec, start_acc, cfg_zero;
    logic             id_wrap, y_wrap, x_wrap, od_wrap;
    logic [IDX_W-1:0] step, x_idx, y_idx;
    logic [ID_W-1:0]  id_idx;
    logic [OD_W-1:0]  od_idx;

    assign start_acc  = (state == ST_IDLE) && start_i;
    assign cfg_zero   = (cfg_id_i == '0) || (cfg_od_i == '0) || (cfg_h_i == '0) || (cfg_w_i == '0);
    assign fire       = req_valid && req.data_ready_i && req.weight_ready_i;
    assign final_fire = fire && id_wrap && y_wrap && x_wrap && od_wrap;
    assign result_dec = result_valid_i && (outstanding != '0);
    assign step       = tile_step(size_type);

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_i) state_next = cfg_zero ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (final_fire) state_next = ST_DRAIN;
            ST_DRAIN: if (outstanding_next == '0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_valid = (state == ST_ISSUE) && (outstanding < CNT_W'(MAX_OUTSTANDING));
        busy_o    = (state == ST_ISSUE) || (state == ST_DRAIN);
        done_o    = (state == ST_DONE);
    end

    always_comb begin
        outstanding_next = outstanding;
        if (fire && !result_dec)
            outstanding_next = outstanding + 1'b1;
        else if (!fire && result_dec)
            outstanding_next = outstanding - 1'b1;
    end

    // armed blocks err_o for stray results after a reset abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_h       <= '0;
            cfg_w       <= '0;
            cfg_id      <= '0;
            cfg_od      <= '0;
            size_type   <= 1'b0;
            outstanding <= '0;
            armed       <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            if (start_acc) begin
                cfg_h     <= cfg_h_i;
                cfg_w     <= cfg_w_i;
                cfg_id    <= cfg_id_i;
                cfg_od    <= cfg_od_i;
                size_type <= cfg_size_type_i;
                armed     <= 1'b1;
                err_o     <= 1'b0;
            end else if (result_valid_i && (outstanding == '0) && armed) begin
                err_o     <= 1'b1;
            end
        end
    end

    wino_loop_ctr #(.W(ID_W), .BW(5)) u_id_ctr (
        .clk(clk), .reset(reset), .clear(start_acc), .inc(fire),
        .step(ID_W'(1)), .bound(cfg_id), .value(id_idx), .wrap_o(id_wrap)
    );

    wino_loop_ctr #(.W(IDX_W), .BW(9)) u_y_ctr (
        .clk(clk), .reset(reset), .clear(start_acc), .inc(fire && id_wrap),
        .step(step), .bound(cfg_w), .value(y_idx), .wrap_o(y_wrap)
    );

    wino_loop_ctr #(.W(IDX_W), .BW(9)) u_x_ctr (
        .clk(clk), .reset(reset), .clear(start_acc), .inc(fire && id_wrap && y_wrap),
        .step(step), .bound(cfg_h), .value(x_idx), .wrap_o(x_wrap)
    );

    wino_loop_ctr #(.W(OD_W), .BW(8)) u_od_ctr (
        .clk(clk), .reset(reset), .clear(start_acc), .inc(fire && id_wrap && y_wrap && x_wrap),
        .step(OD_W'(1)), .bound(cfg_od), .value(od_idx), .wrap_o(od_wrap)
    );

    assign req.req_valid_o        = req_valid;
    assign req.data_x_index_o     = x_idx;
    assign req.data_y_index_o     = y_idx;
    assign req.tile_id_o          = id_idx;
    assign req.weight_od_o        = od_idx;
    assign req.weight_size_type_o = size_type;
    assign req.last_id_o          = (state == ST_ISSUE) && id_wrap;

`ifdef WINO_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_cycles, perf_stalls;

    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (busy_o && (perf_cycles != '1))
                perf_cycles <= perf_cycles + 1'b1;
            if (req_valid && !fire && (perf_stalls != '1))
                perf_stalls <= perf_stalls + 1'b1;
        end
    end

    assign perf_cycles_o = perf_cycles;
    assign perf_stalls_o = perf_stalls;
`else
    assign perf_cycles_o = '0;
    assign perf_stalls_o = '0;
`endif

endmodule

// File: tb/tb_wino_tile_scheduler.sv
// Self-checking bench for wino_tile_scheduler: table of layers checked against
// a nested-loop tile model plus a result-latency scoreboard, then corner cases.
module tb_wino_tile_scheduler;
    import wino_pkg::*;

    localparam int MAX_OUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic [8:0]        cfg_h_i, cfg_w_i;
    logic [4:0]        cfg_id_i;
    logic [7:0]        cfg_od_i;
    logic              cfg_size_type_i;
    logic              result_valid_i;
    logic              busy_o, done_o, err_o;
    logic [PERF_W-1:0] perf_cycles_o, perf_stalls_o;

    wino_tile_scheduler_if req_if ();

    wino_tile_scheduler #(.MAX_OUTSTANDING(MAX_OUT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start_i(start_i),
        .cfg_h_i(cfg_h_i), .cfg_w_i(cfg_w_i), .cfg_id_i(cfg_id_i),
        .cfg_od_i(cfg_od_i), .cfg_size_type_i(cfg_size_type_i),
        .req(req_if), .result_valid_i(result_valid_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .perf_cycles_o(perf_cycles_o), .perf_stalls_o(perf_stalls_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int h; int w; int id; int od;
        bit st; bit rnd; int lat; int n_tiles;
    } layer_t;

    typedef struct { int x; int y; int id; int od; bit last; } tile_t;

    tile_t exp_q[$];
    int    due_q[$];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input int h, input int w, input int id, input int od, input bit st);
        cfg_h_i         = 9'(h);
        cfg_w_i         = 9'(w);
        cfg_id_i        = 5'(id);
        cfg_od_i        = 8'(od);
        cfg_size_type_i = st;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, req_if.req_valid_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_x"}, req_if.data_x_index_o, 0);
        check({tag, "_y"}, req_if.data_y_index_o, 0);
        check({tag, "_id"}, req_if.tile_id_o, 0);
        check({tag, "_od"}, req_if.weight_od_o, 0);
        check({tag, "_last"}, req_if.last_id_o, 0);
        check({tag, "_type"}, req_if.weight_size_type_o, 0);
        check({tag, "_perf_cycles"}, perf_cycles_o, 0);
        check({tag, "_perf_stalls"}, perf_stalls_o, 0);
    endtask

    task automatic run_layer(input layer_t L);
        int    step, out_m, fires, busy_cyc, stalls;
        bit    done_exp, finished, dr, wr, fire, rv;
        tile_t e;
        step = L.st ? TILE_STEP_3X3 : TILE_STEP_1X1;
        exp_q.delete();
        due_q.delete();
        for (int od = 0; od < L.od; od++)
            for (int x = 0; x < L.h; x += step)
                for (int y = 0; y < L.w; y += step)
                    for (int id = 0; id < L.id; id++) begin
                        e = '{x: x, y: y, id: id, od: od, last: (id == L.id - 1)};
                        exp_q.push_back(e);
                    end
        out_m = 0; fires = 0; busy_cyc = 0; stalls = 0;
        done_exp = 0; finished = 0;

        drive_cfg(L.h, L.w, L.id, L.od, L.st);
        start_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        check("start_busy", busy_o, 1);
        check("start_err_clear", err_o, 0);
        check("start_type", req_if.weight_size_type_o, L.st);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            dr = L.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr = L.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            req_if.data_ready_i   = dr;
            req_if.weight_ready_i = wr;
            rv = (due_q.size() > 0) && (due_q[0] == cyc);
            if (rv) void'(due_q.pop_front());
            result_valid_i = rv;
            #1;
            check("done_timing", done_o, done_exp);
            if (done_exp) begin
                check("done_busy_low", busy_o, 0);
                check("done_fire_count", fires, L.n_tiles);
                check("done_err", err_o, 0);
`ifdef WINO_SCHED_PERF_EN
                check("perf_cycles", perf_cycles_o, busy_cyc);
                check("perf_stalls", perf_stalls_o, stalls);
`else
                check("perf_cycles_tied", perf_cycles_o, 0);
                check("perf_stalls_tied", perf_stalls_o, 0);
`endif
                finished = 1;
                break;
            end
            check("req_valid", req_if.req_valid_o, (exp_q.size() > 0) && (out_m < MAX_OUT));
            fire = req_if.req_valid_o && dr && wr;
            if (req_if.req_valid_o && !fire) stalls++;
            busy_cyc++;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check("extra_fire", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tile_x", req_if.data_x_index_o, e.x);
                    check("tile_y", req_if.data_y_index_o, e.y);
                    check("tile_id", req_if.tile_id_o, e.id);
                    check("tile_od", req_if.weight_od_o, e.od);
                    check("tile_last", req_if.last_id_o, e.last);
                end
                fires++;
                out_m++;
                due_q.push_back(cyc + L.lat);
            end
            if (rv) out_m--;
            done_exp = (exp_q.size() == 0) && (out_m == 0);
            next_cycle();
        end
        if (!finished) check("layer_timeout", 0, 1);
        result_valid_i        = 1'b0;
        req_if.data_ready_i   = 1'b0;
        req_if.weight_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            check("done_once", done_o, 0);
        end
    endtask

    layer_t layers[5];

    initial begin
        layers[0] = '{h: 8, w: 8,  id: 2,  od: 1, st: 1, rnd: 0, lat: 3, n_tiles: 8};
        layers[1] = '{h: 7, w: 7,  id: 1,  od: 2, st: 0, rnd: 0, lat: 3, n_tiles: 8};
        layers[2] = '{h: 5, w: 9,  id: 3,  od: 1, st: 1, rnd: 1, lat: 5, n_tiles: 18};
        layers[3] = '{h: 6, w: 6,  id: 1,  od: 3, st: 0, rnd: 1, lat: 1, n_tiles: 3};
        layers[4] = '{h: 4, w: 13, id: 16, od: 1, st: 1, rnd: 1, lat: 6, n_tiles: 64};

        reset = 1'b1; start_i = 1'b0; result_valid_i = 1'b0;
        req_if.data_ready_i = 1'b0; req_if.weight_ready_i = 1'b0;
        drive_cfg(0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        check_all_zero("reset");
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < 5; i++) run_layer(layers[i]);

        // Stray result in IDLE after a completed layer is sticky.
        result_valid_i = 1'b1;
        next_cycle();
        result_valid_i = 1'b0;
        check("err_set", err_o, 1);
        next_cycle();
        check("err_sticky", err_o, 1);

        // Zero input channels: straight to DONE, and the start clears err.
        drive_cfg(8, 8, 0, 1, 1);
        start_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        check("zero_done", done_o, 1);
        check("zero_req_valid", req_if.req_valid_o, 0);
        check("zero_busy", busy_o, 0);
        check("zero_err_clear", err_o, 0);
        next_cycle();
        check("zero_done_pulse", done_o, 0);

        // Credit limit with results withheld.
        drive_cfg(8, 8, 16, 1, 1);
        req_if.data_ready_i = 1'b1; req_if.weight_ready_i = 1'b1;
        start_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("credit_fill", req_if.req_valid_o, k < MAX_OUT);
            next_cycle();
        end
        check("credit_tile_id", req_if.tile_id_o, MAX_OUT);
        result_valid_i = 1'b1;
        #1 check("credit_held", req_if.req_valid_o, 0);
        next_cycle();
        check("credit_reopen", req_if.req_valid_o, 1);
        next_cycle();
        result_valid_i = 1'b0;
        check("credit_coincide", req_if.req_valid_o, 1);
        next_cycle();
        check("credit_full_again", req_if.req_valid_o, 0);
        check("credit_tile_id2", req_if.tile_id_o, MAX_OUT + 2);

        // Abort mid-ISSUE, then late results must not raise err.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check_all_zero("abort");
        req_if.data_ready_i = 1'b0; req_if.weight_ready_i = 1'b0;
        result_valid_i = 1'b1;
        next_cycle();
        next_cycle();
        result_valid_i = 1'b0;
        check("abort_no_err", err_o, 0);
        check("abort_no_done", done_o, 0);
        run_layer(layers[0]);

        // Half-ready stall: data ready toggles, weight ready held low.
        drive_cfg(8, 8, 2, 1, 1);
        start_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            req_if.data_ready_i   = k[0];
            req_if.weight_ready_i = 1'b0;
            #1;
            check("stall_req_valid", req_if.req_valid_o, 1);
            check("stall_id", req_if.tile_id_o, 0);
            check("stall_y", req_if.data_y_index_o, 0);
`ifdef WINO_SCHED_PERF_EN
            check("stall_perf", perf_stalls_o, k);
`else
            check("stall_perf_tied", perf_stalls_o, 0);
`endif
            next_cycle();
        end
        req_if.data_ready_i = 1'b0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        check_all_zero("final_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
